// File: rtl/controller_mc.sv
// controller_mc: multi-cycle main control unit for the RV32I core.
// Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB with
// valid/ack handshakes to instruction and data memory. Flags illegal
// encodings, bounds data-memory waits with a timeout and counts retired
// instructions.
//
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   instr     in   [31:0] instruction register contents (valid from DECODE)
//   imem_ack  in   instruction memory ack
//   dmem_ack  in   data memory ack
//   br_taken  in   branch comparator result
//   imem_req  out  instruction fetch request
//   ir_en     out  load instruction register
//   dmem_req  out  data access request
//   dmem_we   out  data access is a store
//   aluop     out  [ALUOP_W-1:0] ALU operation
//   sel_a     out  ALU A: 0=rs1, 1=PC
//   sel_b     out  ALU B: 0=rs2, 1=imm
//   rf_en     out  register file write enable
//   wb_sel    out  [1:0] 0=ALU, 1=load data, 2=PC+4, 3=imm
//   pc_en     out  update PC
//   pc_sel    out  0=PC+4, 1=ALU result
//   illegal   out  pulse on illegal instruction
//   bus_err   out  pulse on data timeout
//   retire    out  pulse per completed instruction
//   instret   out  [CNT_W-1:0] retired-instruction count
//
// state  | meaning
// -------+--------------------------------------------------
// IDLE   | after reset, outputs quiet, goes to FETCH
// FETCH  | imem_req held until imem_ack, ir_en on ack
// DECODE | classify instr, illegal -> skip to next FETCH
// EXEC   | ALU op; branches resolve and retire here
// MEM    | dmem_req held until ack or timeout
// WB     | register write, PC update, retire

module controller_mc #(
    parameter int ALUOP_W     = 4,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [31:0]        instr,
    input  logic               imem_ack,
    input  logic               dmem_ack,
    input  logic               br_taken,
    output logic               imem_req,
    output logic               ir_en,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [ALUOP_W-1:0] aluop,
    output logic               sel_a,
    output logic               sel_b,
    output logic               rf_en,
    output logic [1:0]         wb_sel,
    output logic               pc_en,
    output logic               pc_sel,
    output logic               illegal,
    output logic               bus_err,
    output logic               retire,
    output logic [CNT_W-1:0]   instret
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;
    localparam logic [3:0] ALU_NULL = 4'd10;

    localparam int TO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = (MEM_TIMEOUT > 0) ? TO_W'(MEM_TIMEOUT - 1) : '0;

    state_t state, state_nxt;
    logic [TO_W-1:0] to_cnt;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic is_r, is_i, is_load, is_store, is_branch, is_jal, is_lui;
    logic bad_enc;
    logic mem_timeout;
    logic [3:0] alu_code;
    logic unused_instr;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    // register and immediate fields are consumed by the datapath, not here
    assign unused_instr = ^{instr[24:15], instr[11:7]};

    assign is_r      = (opcode == OP_R);
    assign is_i      = (opcode == OP_I);
    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);
    assign is_branch = (opcode == OP_BRANCH);
    assign is_jal    = (opcode == OP_JAL);
    assign is_lui    = (opcode == OP_LUI);

    always_comb begin
        bad_enc = !(is_r || is_i || is_load || is_store || is_branch || is_jal || is_lui);
        // funct7=0100000 is only defined for SUB and SRA
        if (is_r && !((funct7 == 7'h00) ||
                      (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101))))
            bad_enc = 1'b1;
        // immediate shifts carry funct7 in imm[11:5]
        if (is_i && funct3 == 3'b001 && funct7 != 7'h00)
            bad_enc = 1'b1;
        if (is_i && funct3 == 3'b101 && funct7 != 7'h00 && funct7 != 7'h20)
            bad_enc = 1'b1;
    end

    always_comb begin
        alu_code = ALU_ADD;
        if (is_r || is_i) begin
            case (funct3)
                3'b000:  alu_code = (is_r && funct7[5]) ? ALU_SUB : ALU_ADD;
                3'b001:  alu_code = ALU_SLL;
                3'b010:  alu_code = ALU_SLT;
                3'b011:  alu_code = ALU_SLTU;
                3'b100:  alu_code = ALU_XOR;
                3'b101:  alu_code = funct7[5] ? ALU_SRA : ALU_SRL;
                3'b110:  alu_code = ALU_OR;
                default: alu_code = ALU_AND;
            endcase
        end else if (is_lui) begin
            alu_code = ALU_NULL;
        end
    end

    assign mem_timeout = (MEM_TIMEOUT > 0) && (to_cnt == TO_LAST);

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   state_nxt = S_FETCH;
            S_FETCH:  if (imem_ack) state_nxt = S_DECODE;
            S_DECODE: state_nxt = bad_enc ? S_FETCH : S_EXEC;
            S_EXEC: begin
                if (is_branch)
                    state_nxt = S_FETCH;
                else if (is_load || is_store)
                    state_nxt = S_MEM;
                else
                    state_nxt = S_WB;
            end
            S_MEM: begin
                if (dmem_ack)
                    state_nxt = is_store ? S_FETCH : S_WB;
                else if (mem_timeout)
                    state_nxt = S_FETCH;
            end
            S_WB:     state_nxt = S_FETCH;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // output logic
    always_comb begin
        imem_req = 1'b0;
        ir_en    = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        aluop    = '0;
        sel_a    = 1'b0;
        sel_b    = 1'b0;
        rf_en    = 1'b0;
        wb_sel   = 2'd0;
        pc_en    = 1'b0;
        pc_sel   = 1'b0;
        illegal  = 1'b0;
        bus_err  = 1'b0;
        retire   = 1'b0;
        if (state == S_EXEC || state == S_MEM || state == S_WB) begin
            aluop = ALUOP_W'(alu_code);
            sel_a = is_branch || is_jal;
            sel_b = is_i || is_load || is_store || is_branch || is_jal;
        end
        case (state)
            S_FETCH: begin
                imem_req = 1'b1;
                ir_en    = imem_ack;
            end
            S_DECODE: begin
                illegal = bad_enc;
                pc_en   = bad_enc;
            end
            S_EXEC: begin
                if (is_branch) begin
                    pc_en  = 1'b1;
                    pc_sel = br_taken;
                    retire = 1'b1;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = is_store;
                // ack takes priority over a coincident timeout
                if (dmem_ack) begin
                    pc_en  = is_store;
                    retire = is_store;
                end else if (mem_timeout) begin
                    bus_err = 1'b1;
                    pc_en   = 1'b1;
                end
            end
            S_WB: begin
                rf_en  = 1'b1;
                pc_en  = 1'b1;
                retire = 1'b1;
                pc_sel = is_jal;
                if (is_load)
                    wb_sel = 2'd1;
                else if (is_jal)
                    wb_sel = 2'd2;
                else if (is_lui)
                    wb_sel = 2'd3;
                else
                    wb_sel = 2'd0;
            end
            default: ;
        endcase
    end

    // MEM wait counter, held at zero outside MEM so every entry starts fresh
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            to_cnt <= '0;
        else if (state != S_MEM)
            to_cnt <= '0;
        else if (!dmem_ack && !mem_timeout)
            to_cnt <= to_cnt + TO_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            instret <= '0;
        else if (retire)
            instret <= instret + CNT_W'(1);
    end

endmodule

// File: tb/tb_controller_mc.sv
// Directed testbench for controller_mc with hand-computed expectations.
module tb_controller_mc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        imem_ack, dmem_ack, br_taken;
    logic        imem_req, ir_en, dmem_req, dmem_we;
    logic [3:0]  aluop;
    logic        sel_a, sel_b, rf_en;
    logic [1:0]  wb_sel;
    logic        pc_en, pc_sel, illegal, bus_err, retire;
    logic [31:0] instret;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int exp_instret = 0;

    controller_mc #(.ALUOP_W(4), .MEM_TIMEOUT(16), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr),
        .imem_ack(imem_ack), .dmem_ack(dmem_ack), .br_taken(br_taken),
        .imem_req(imem_req), .ir_en(ir_en), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .aluop(aluop), .sel_a(sel_a), .sel_b(sel_b), .rf_en(rf_en), .wb_sel(wb_sel),
        .pc_en(pc_en), .pc_sel(pc_sel), .illegal(illegal), .bus_err(bus_err),
        .retire(retire), .instret(instret)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Entered in a FETCH cycle; leaves in the DECODE cycle.
    task automatic do_fetch(input logic [31:0] ins, input int waits);
        instr = ins;
        for (int i = 0; i <= waits; i++) begin
            imem_ack = (i == waits);
            #1;
            check("fetch imem_req", imem_req, 1);
            check("fetch ir_en", ir_en, (i == waits));
            tick;
        end
        imem_ack = 1'b0;
    endtask

    task automatic chk_decode(input logic exp_ill);
        #1;
        check("decode illegal", illegal, exp_ill);
        check("decode pc_en", pc_en, exp_ill);
        check("decode pc_sel", pc_sel, 0);
        check("decode rf_en", rf_en, 0);
        check("decode retire", retire, 0);
    endtask

    task automatic chk_back_in_fetch(input string tag, input int start, input int exp_cycles);
        #1;
        check({tag, " cycles"}, cyc - start, exp_cycles);
        check({tag, " refetch"}, imem_req, 1);
        check({tag, " instret"}, instret, exp_instret);
    endtask

    // R / I-ALU / LUI / JAL
    task automatic alu_instr(input string tag, input logic [31:0] ins, input int waits,
                             input logic [3:0] e_aluop, input logic e_sel_a, input logic e_sel_b,
                             input logic [1:0] e_wb, input logic e_pcsel);
        int start;
        start = cyc;
        do_fetch(ins, waits);
        chk_decode(1'b0);
        tick;
        #1;
        check({tag, " exec aluop"}, aluop, e_aluop);
        check({tag, " exec sel_a"}, sel_a, e_sel_a);
        check({tag, " exec sel_b"}, sel_b, e_sel_b);
        check({tag, " exec rf_en"}, rf_en, 0);
        tick;
        #1;
        check({tag, " wb rf_en"}, rf_en, 1);
        check({tag, " wb wb_sel"}, wb_sel, e_wb);
        check({tag, " wb pc_en"}, pc_en, 1);
        check({tag, " wb pc_sel"}, pc_sel, e_pcsel);
        check({tag, " wb retire"}, retire, 1);
        exp_instret++;
        tick;
        chk_back_in_fetch(tag, start, 4 + waits);
    endtask

    // LOAD / STORE; timeout means dmem_ack never comes
    task automatic mem_instr(input string tag, input logic [31:0] ins, input logic is_st,
                             input int waits, input logic to);
        int start, n;
        logic last;
        start = cyc;
        n = to ? 16 : waits + 1;
        do_fetch(ins, 0);
        chk_decode(1'b0);
        tick;
        #1;
        check({tag, " exec aluop"}, aluop, 0);
        check({tag, " exec sel_b"}, sel_b, 1);
        check({tag, " exec dmem_req"}, dmem_req, 0);
        tick;
        for (int i = 0; i < n; i++) begin
            last = (i == n - 1);
            dmem_ack = !to && last;
            #1;
            check({tag, " mem dmem_req"}, dmem_req, 1);
            check({tag, " mem dmem_we"}, dmem_we, is_st);
            check({tag, " mem bus_err"}, bus_err, to && last);
            check({tag, " mem pc_en"}, pc_en, (to || is_st) && last);
            check({tag, " mem retire"}, retire, !to && is_st && last);
            tick;
        end
        dmem_ack = 1'b0;
        if (!to && is_st) exp_instret++;
        if (!to && !is_st) begin
            #1;
            check({tag, " wb rf_en"}, rf_en, 1);
            check({tag, " wb wb_sel"}, wb_sel, 1);
            check({tag, " wb retire"}, retire, 1);
            exp_instret++;
            tick;
        end
        chk_back_in_fetch(tag, start, 3 + n + ((!to && !is_st) ? 1 : 0));
    endtask

    task automatic ill_instr(input string tag, input logic [31:0] ins);
        int start;
        start = cyc;
        do_fetch(ins, 0);
        chk_decode(1'b1);
        tick;
        #1;
        check({tag, " rf_en"}, rf_en, 0);
        chk_back_in_fetch(tag, start, 2);
    endtask

    task automatic br_instr(input string tag, input logic taken);
        int start;
        start = cyc;
        do_fetch(32'h00000463, 0);
        chk_decode(1'b0);
        tick;
        br_taken = taken;
        #1;
        check({tag, " pc_en"}, pc_en, 1);
        check({tag, " pc_sel"}, pc_sel, taken);
        check({tag, " retire"}, retire, 1);
        check({tag, " sel_a"}, sel_a, 1);
        check({tag, " sel_b"}, sel_b, 1);
        check({tag, " aluop"}, aluop, 0);
        exp_instret++;
        tick;
        br_taken = 1'b0;
        chk_back_in_fetch(tag, start, 3);
    endtask

    initial begin
        rst_n    = 1'b0;
        instr    = 32'h0;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        br_taken = 1'b0;
        #2;
        check("reset imem_req", imem_req, 0);
        check("reset dmem_req", dmem_req, 0);
        check("reset pc_en", pc_en, 0);
        check("reset retire", retire, 0);
        check("reset instret", instret, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("idle imem_req", imem_req, 0);
        check("idle aluop", aluop, 0);
        tick;

        alu_instr("add",  32'h002081B3, 2, 4'd0,  1'b0, 1'b0, 2'd0, 1'b0);
        alu_instr("srai", 32'h4030D093, 0, 4'd7,  1'b0, 1'b1, 2'd0, 1'b0);
        alu_instr("lui",  32'h123450B7, 0, 4'd10, 1'b0, 1'b0, 2'd3, 1'b0);
        alu_instr("jal",  32'h008000EF, 0, 4'd0,  1'b1, 1'b1, 2'd2, 1'b1);
        mem_instr("lw",       32'h0000A183, 1'b0, 5, 1'b0);
        mem_instr("sw_tmo",   32'h00112023, 1'b1, 0, 1'b1);
        mem_instr("sw_ack",   32'h00112023, 1'b1, 1, 1'b0);
        ill_instr("ill_op",   32'h0000007F);
        ill_instr("ill_f7",   32'h40001033);
        br_instr("beq_taken", 1'b1);
        br_instr("beq_not",   1'b0);

        // reset in the middle of a data access
        do_fetch(32'h0000A183, 0);
        chk_decode(1'b0);
        tick;
        tick;
        tick;
        #1;
        check("midrst dmem_req before", dmem_req, 1);
        rst_n = 1'b0;
        #1;
        check("midrst dmem_req", dmem_req, 0);
        check("midrst instret", instret, 0);
        exp_instret = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("midrst idle imem_req", imem_req, 0);
        tick;
        #1;
        check("midrst refetch", imem_req, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
